// File: rtl/lattice_result_collector.sv
// Tail of a multi-core lattice block: merges local nonce hits into the upstream result chain
// through a FIFO, and delays the block status strobes by OUT_DELAY cycles.
module lattice_result_collector #(
  parameter int unsigned LOG2_NUM_CORES = 1,
  parameter int unsigned NUM_LOCAL      = 2,
  parameter int unsigned INDEX          = 0,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned OUT_DELAY      = 1,
  parameter int unsigned NONCE_BITS     = 32,
  localparam int unsigned CntW          = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned PtrW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            up_valid,
  input  logic                            up_success,
  input  logic [NONCE_BITS-1:0]           up_nonce,
  input  logic [LOG2_NUM_CORES-1:0]       up_partition,
  input  logic [NUM_LOCAL-1:0]            loc_success,
  input  logic [NUM_LOCAL*NONCE_BITS-1:0] loc_nonce,
  input  logic                            valid_i,
  input  logic                            newBlock_i,
  output logic                            out_valid,
  output logic                            out_success,
  output logic [NONCE_BITS-1:0]           out_nonce,
  output logic [LOG2_NUM_CORES-1:0]       out_partition,
  output logic                            validOut,
  output logic                            newBlockOut,
  output logic                            overflow,
  output logic [CntW-1:0]                 fifo_count
);

  logic [NONCE_BITS-1:0]     mem_nonce_q [FIFO_DEPTH];
  logic [NONCE_BITS-1:0]     mem_nonce_d [FIFO_DEPTH];
  logic [LOG2_NUM_CORES-1:0] mem_part_q  [FIFO_DEPTH];
  logic [LOG2_NUM_CORES-1:0] mem_part_d  [FIFO_DEPTH];
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_success_q, out_success_d;
  logic [NONCE_BITS-1:0]     out_nonce_q, out_nonce_d;
  logic [LOG2_NUM_CORES-1:0] out_part_q, out_part_d;

  logic                      up_hit;
  logic                      pop;
  logic                      dropped;
  int unsigned               n_push;
  int unsigned               n_free;
  logic [PtrW-1:0]           wr_idx;

  function automatic logic [LOG2_NUM_CORES-1:0] ch_part(input int unsigned ch);
    int unsigned v;
    v = INDEX * NUM_LOCAL + ch;
    return v[LOG2_NUM_CORES-1:0];
  endfunction

  assign up_hit = up_valid & up_success;
  // Upstream hits own the slot; a flush also blocks the pop so nothing stale escapes.
  assign pop    = (count_q != '0) & ~up_hit & ~newBlock_i;

  always_comb begin
    mem_nonce_d = mem_nonce_q;
    mem_part_d  = mem_part_q;
    n_push      = 0;
    dropped     = 1'b0;
    wr_idx      = wr_ptr_q;
    n_free      = FIFO_DEPTH - 32'(count_q) + 32'(pop);
    if (!newBlock_i) begin
      for (int unsigned ch = 0; ch < NUM_LOCAL; ch++) begin
        if (loc_success[ch]) begin
          if (n_push < n_free) begin
            wr_idx              = PtrW'((32'(wr_ptr_q) + n_push) & (FIFO_DEPTH - 1));
            mem_nonce_d[wr_idx] = loc_nonce[ch*NONCE_BITS +: NONCE_BITS];
            mem_part_d[wr_idx]  = ch_part(ch);
            n_push              = n_push + 1;
          end else begin
            dropped = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    if (newBlock_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      wr_ptr_d   = PtrW'((32'(wr_ptr_q) + n_push) & (FIFO_DEPTH - 1));
      rd_ptr_d   = pop ? PtrW'((32'(rd_ptr_q) + 1) & (FIFO_DEPTH - 1)) : rd_ptr_q;
      count_d    = CntW'(32'(count_q) + n_push - 32'(pop));
      overflow_d = overflow_q | dropped;
    end
  end

  always_comb begin
    out_valid_d   = up_valid | pop;
    out_success_d = up_hit | pop;
    out_nonce_d   = out_nonce_q;
    out_part_d    = out_part_q;
    if (up_hit) begin
      out_nonce_d = up_nonce;
      out_part_d  = up_partition;
    end else if (pop) begin
      out_nonce_d = mem_nonce_q[rd_ptr_q];
      out_part_d  = mem_part_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_nonce_q[i] <= '0;
        mem_part_q[i]  <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_success_q <= 1'b0;
      out_nonce_q   <= '0;
      out_part_q    <= '0;
    end else begin
      mem_nonce_q   <= mem_nonce_d;
      mem_part_q    <= mem_part_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      out_valid_q   <= out_valid_d;
      out_success_q <= out_success_d;
      out_nonce_q   <= out_nonce_d;
      out_part_q    <= out_part_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_success   = out_success_q;
  assign out_nonce     = out_nonce_q;
  assign out_partition = out_part_q;
  assign overflow      = overflow_q;
  assign fifo_count    = count_q;

  // Status strobes travel on their own shift line, bit 1 = valid, bit 0 = newBlock.
  if (OUT_DELAY == 0) begin : g_no_dly
    assign validOut    = valid_i;
    assign newBlockOut = newBlock_i;
  end else begin : g_dly
    logic [1:0] dly_q [OUT_DELAY];
    logic [1:0] dly_d [OUT_DELAY];

    always_comb begin
      dly_d[0] = {valid_i, newBlock_i};
      for (int i = 1; i < int'(OUT_DELAY); i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(OUT_DELAY); i++) begin
          dly_q[i] <= 2'b00;
        end
      end else begin
        dly_q <= dly_d;
      end
    end

    assign validOut    = dly_q[OUT_DELAY-1][1];
    assign newBlockOut = dly_q[OUT_DELAY-1][0];
  end

endmodule

// File: tb/tb_lattice_result_collector.sv
// Scoreboard bench for lattice_result_collector: directed stimulus queues expected hits,
// a negedge monitor pops and compares every emitted hit.
module tb_lattice_result_collector;

  localparam int unsigned NB = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid, up_success;
  logic [NB-1:0] up_nonce;
  logic [0:0]    up_partition;
  logic [1:0]    loc_success;
  logic [2*NB-1:0] loc_nonce;
  logic          valid_i, newBlock_i;

  logic          out_valid, out_success, validOut, newBlockOut, overflow;
  logic [NB-1:0] out_nonce;
  logic [0:0]    out_partition;
  logic [2:0]    fifo_count;

  logic          d0_out_valid, d0_out_success, d0_validOut, d0_newBlockOut, d0_overflow;
  logic [NB-1:0] d0_out_nonce;
  logic [0:0]    d0_out_partition;
  logic [2:0]    d0_fifo_count;

  typedef struct packed {
    logic [NB-1:0] nonce;
    logic [0:0]    part;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lattice_result_collector #(
    .LOG2_NUM_CORES(1), .NUM_LOCAL(2), .INDEX(0), .FIFO_DEPTH(4), .OUT_DELAY(3), .NONCE_BITS(NB)
  ) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_success(up_success), .up_nonce(up_nonce),
    .up_partition(up_partition), .loc_success(loc_success), .loc_nonce(loc_nonce),
    .valid_i(valid_i), .newBlock_i(newBlock_i), .out_valid(out_valid),
    .out_success(out_success), .out_nonce(out_nonce), .out_partition(out_partition),
    .validOut(validOut), .newBlockOut(newBlockOut), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  lattice_result_collector #(
    .LOG2_NUM_CORES(1), .NUM_LOCAL(2), .INDEX(0), .FIFO_DEPTH(4), .OUT_DELAY(0), .NONCE_BITS(NB)
  ) dut0 (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_success(up_success), .up_nonce(up_nonce),
    .up_partition(up_partition), .loc_success(loc_success), .loc_nonce(loc_nonce),
    .valid_i(valid_i), .newBlock_i(newBlock_i), .out_valid(d0_out_valid),
    .out_success(d0_out_success), .out_nonce(d0_out_nonce), .out_partition(d0_out_partition),
    .validOut(d0_validOut), .newBlockOut(d0_newBlockOut), .overflow(d0_overflow),
    .fifo_count(d0_fifo_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_hit(input logic [NB-1:0] n, input logic [0:0] p);
    exp_t e;
    e.nonce = n;
    e.part  = p;
    sb.push_back(e);
  endtask

  task automatic up_drive(input logic v, input logic s, input logic [NB-1:0] n,
                          input logic [0:0] p);
    up_valid     = v;
    up_success   = s;
    up_nonce     = n;
    up_partition = p;
  endtask

  // Monitor: every downstream hit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_success) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got nonce %0h part %0h want none", out_nonce,
                 out_partition);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_nonce !== e.nonce || out_partition !== e.part) begin
          errors++;
          $display("FAIL sb_hit: got nonce %0h part %0h want nonce %0h part %0h",
                   out_nonce, out_partition, e.nonce, e.part);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    up_drive(1'b0, 1'b0, '0, '0);
    loc_success = '0;
    loc_nonce   = '0;
    valid_i     = 1'b0;
    newBlock_i  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_out", {out_valid, out_success, out_nonce, out_partition}, '0);
      check("idle_stat", {validOut, newBlockOut, overflow, fifo_count}, '0);
    end

    // Upstream hit passes straight through.
    up_drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    expect_hit(32'hDEADBEEF, 1'b1);
    tick();
    up_drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    up_drive(1'b0, 1'b0, '0, '0);
    check("up_nohit_valid", out_valid, 1'b1);
    check("up_nohit_success", out_success, 1'b0);

    // Both channels hit together.
    loc_success = 2'b11;
    loc_nonce   = {32'h20, 32'h10};
    expect_hit(32'h10, 1'b0);
    expect_hit(32'h20, 1'b1);
    tick();
    loc_success = '0;
    check("dual_cnt2", fifo_count, 3'd2);
    tick();
    check("dual_cnt1", fifo_count, 3'd1);
    tick();
    check("dual_cnt0", fifo_count, 3'd0);

    // Local hit waits behind three upstream hits.
    up_drive(1'b1, 1'b1, 32'hA1, 1'b0);
    expect_hit(32'hA1, 1'b0);
    loc_success = 2'b01;
    loc_nonce   = {32'h0, 32'h55};
    tick();
    loc_success = '0;
    up_drive(1'b1, 1'b1, 32'hA2, 1'b1);
    expect_hit(32'hA2, 1'b1);
    tick();
    up_drive(1'b1, 1'b1, 32'hA3, 1'b0);
    expect_hit(32'hA3, 1'b0);
    expect_hit(32'h55, 1'b0);
    tick();
    up_drive(1'b0, 1'b0, '0, '0);
    check("prio_held", fifo_count, 3'd1);
    tick();
    tick();
    check("prio_drained", fifo_count, 3'd0);

    // Fill under continuous upstream hits, then overflow.
    up_drive(1'b1, 1'b1, 32'hB1, 1'b1);
    expect_hit(32'hB1, 1'b1);
    loc_success = 2'b11;
    loc_nonce   = {32'h2, 32'h1};
    tick();
    check("fill_cnt2", fifo_count, 3'd2);
    up_drive(1'b1, 1'b1, 32'hB2, 1'b1);
    expect_hit(32'hB2, 1'b1);
    loc_success = 2'b01;
    loc_nonce   = {32'h0, 32'h3};
    tick();
    check("fill_cnt3", fifo_count, 3'd3);
    check("fill_noovf", overflow, 1'b0);
    up_drive(1'b1, 1'b1, 32'hB3, 1'b1);
    expect_hit(32'hB3, 1'b1);
    loc_success = 2'b11;
    loc_nonce   = {32'h5, 32'h4};
    tick();
    check("part_drop_cnt", fifo_count, 3'd4);
    check("part_drop_ovf", overflow, 1'b1);
    up_drive(1'b1, 1'b1, 32'hB4, 1'b1);
    expect_hit(32'hB4, 1'b1);
    loc_success = 2'b01;
    loc_nonce   = {32'h0, 32'h6};
    tick();
    check("full_cnt", fifo_count, 3'd4);
    check("full_ovf", overflow, 1'b1);

    // Flush: queued hits and a same-cycle local hit vanish, upstream still passes.
    up_drive(1'b1, 1'b1, 32'hCAFE, 1'b0);
    expect_hit(32'hCAFE, 1'b0);
    loc_success = 2'b10;
    loc_nonce   = {32'h99, 32'h0};
    newBlock_i  = 1'b1;
    tick();
    up_drive(1'b0, 1'b0, '0, '0);
    loc_success = '0;
    newBlock_i  = 1'b0;
    check("flush_cnt", fifo_count, 3'd0);
    check("flush_ovf", overflow, 1'b0);
    check("d0_nb_pre", d0_newBlockOut, 1'b0);
    tick();
    check("nb_dly1", newBlockOut, 1'b0);
    tick();
    check("nb_dly3", newBlockOut, 1'b1);
    repeat (4) tick();
    check("flush_idle_cnt", fifo_count, 3'd0);

    // Push and pop in the same cycle.
    loc_success = 2'b01;
    loc_nonce   = {32'h0, 32'h77};
    expect_hit(32'h77, 1'b0);
    tick();
    loc_nonce   = {32'h0, 32'h88};
    expect_hit(32'h88, 1'b0);
    tick();
    loc_success = '0;
    check("pushpop_cnt", fifo_count, 3'd1);
    tick();
    check("pushpop_drain", fifo_count, 3'd0);

    // Strobe delay: 3 stages on dut, pass-through on dut0.
    valid_i = 1'b1;
    #1;
    check("d0_valid_pass", d0_validOut, 1'b1);
    check("valid_dly0", validOut, 1'b0);
    tick();
    valid_i = 1'b0;
    #1;
    check("d0_valid_clear", d0_validOut, 1'b0);
    check("valid_dly1", validOut, 1'b0);
    tick();
    check("valid_dly2", validOut, 1'b0);
    tick();
    check("valid_dly3", validOut, 1'b1);
    tick();
    check("valid_dly4", validOut, 1'b0);

    repeat (5) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
